// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver (OVERSAMPLE ticks/bit) feeding a FWFT byte FIFO.
// Ports: clk, RSTn (async low), tick_x16, RXD in; rd_en pop, err_clr clears sticky
//   frame_err_o/overrun_o; data_o/empty_o/full_o/count_o FIFO view; busy_o = rx active.
// Optional macro UART_RX_MAJORITY_EN: 2-of-3 majority sampling around mid-bit.
module uart_rx_fifo #(
  parameter int OVERSAMPLE = 16,
  parameter int DEPTH      = 16
) (
  input  logic                     clk,
  input  logic                     RSTn,
  input  logic                     tick_x16,
  input  logic                     RXD,
  input  logic                     rd_en,
  input  logic                     err_clr,
  output logic [7:0]               data_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     busy_o,
  output logic                     frame_err_o,
  output logic                     overrun_o
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t state, state_n;

  logic          rx_meta;
  logic          rxs;
  logic          rxs_prev;
  logic [2:0]    sync_vld;
  logic          fall;
  logic          bit_s;

  logic [TW-1:0] tcnt, tcnt_n;
  logic [2:0]    bitcnt, bitcnt_n;
  logic [7:0]    shreg, shreg_n;
  logic          push_req;
  logic          fe_set;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [CW-1:0] count_n;
  logic [7:0]    head_n;
  logic          pop;
  logic          push;
  logic          ov_set;

  // sync_vld marks when rxs / rxs_prev hold real line values rather than
  // reset fill, so a line held low through reset is not seen as a start edge.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
      sync_vld <= '0;
    end else begin
      rx_meta  <= RXD;
      rxs      <= rx_meta;
      rxs_prev <= rxs;
      sync_vld <= {sync_vld[1:0], 1'b1};
    end
  end

  assign fall = sync_vld[2] & rxs_prev & ~rxs;

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      hist <= 2'b11;
    end else if (tick_x16) begin
      hist <= {hist[0], rxs};
    end
  end

  // hist holds rxs at the two ticks before the sampling tick.
  assign bit_s = (hist[1] & hist[0]) |
                 (hist[1] & rxs) |
                 (hist[0] & rxs);
`else
  assign bit_s = rxs;
`endif

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state  <= IDLE;
      tcnt   <= '0;
      bitcnt <= '0;
      shreg  <= '0;
    end else begin
      state  <= state_n;
      tcnt   <= tcnt_n;
      bitcnt <= bitcnt_n;
      shreg  <= shreg_n;
    end
  end

  always_comb begin
    state_n  = state;
    tcnt_n   = tcnt;
    bitcnt_n = bitcnt;
    shreg_n  = shreg;
    push_req = 1'b0;
    fe_set   = 1'b0;
    unique case (state)
      IDLE: begin
        if (fall) begin
          state_n = START;
          tcnt_n  = '0;
        end
      end
      START: begin
        if (tick_x16) begin
          if (tcnt == T_HALF) begin
            tcnt_n   = '0;
            bitcnt_n = '0;
            state_n  = bit_s ? IDLE : DATA;
          end else begin
            tcnt_n = tcnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick_x16) begin
          // tcnt wraps to 0 after T_LAST (power-of-2 width)
          tcnt_n = tcnt + 1'b1;
          if (tcnt == T_LAST) begin
            shreg_n  = {bit_s, shreg[7:1]};
            bitcnt_n = bitcnt + 1'b1;
            if (bitcnt == 3'd7) begin
              state_n = STOP;
            end
          end
        end
      end
      STOP: begin
        if (tick_x16) begin
          tcnt_n = tcnt + 1'b1;
          if (tcnt == T_LAST) begin
            state_n  = IDLE;
            push_req = bit_s;
            fe_set   = ~bit_s;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy_o = (state != IDLE);

  assign pop    = rd_en & ~empty_o;
  assign push   = push_req & (~full_o | pop);
  assign ov_set = push_req & full_o & ~pop;
  assign rd_nxt = rd_ptr + 1'b1;

  always_comb begin
    count_n = count_o;
    unique case (1'b1)
      push & ~pop: count_n = count_o + 1'b1;
      pop & ~push: count_n = count_o - 1'b1;
      default:     count_n = count_o;
    endcase
  end

  // Registered head: next entry after a pop, or the incoming byte when it
  // lands in an empty (or emptying) FIFO.
  always_comb begin
    head_n = data_o;
    if (pop) begin
      if (count_o > CW'(1)) begin
        head_n = mem[rd_nxt];
      end else if (push) begin
        head_n = shreg;
      end
    end else if (empty_o && push) begin
      head_n = shreg;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= shreg;
    end
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
      empty_o <= 1'b1;
      full_o  <= 1'b0;
      data_o  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_nxt;
      end
      count_o <= count_n;
      empty_o <= (count_n == '0);
      full_o  <= (count_n == C_FULL);
      data_o  <= head_n;
    end
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      frame_err_o <= (frame_err_o & ~err_clr) | fe_set;
      overrun_o   <= (overrun_o & ~err_clr) | ov_set;
    end
  end

endmodule
